// File: rtl/ccu_snoop_arbiter.sv
`default_nettype none
// ============================================================================
// ccu_snoop_arbiter: round-robin share of the CCU snoop port, one AC/CR/CD txn
// Revision: 1.0 - initial release
// ============================================================================
module ccu_snoop_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaskWidth = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_ac_valid_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_ac_addr_i,
  input  logic [NumReq-1:0][3:0]              req_ac_snoop_i,
  input  logic [NumReq-1:0][2:0]              req_ac_prot_i,
  input  logic [NumReq-1:0][MaskWidth-1:0]    req_domain_mask_i,
  output logic [NumReq-1:0]                   req_ac_ready_o,
  output logic [NumReq-1:0]                   req_cr_valid_o,
  input  logic [NumReq-1:0]                   req_cr_ready_i,
  output logic [NumReq-1:0]                   req_cd_valid_o,
  input  logic [NumReq-1:0]                   req_cd_ready_i,
  output logic [4:0]                          req_cr_resp_o,
  output logic [DataWidth-1:0]                req_cd_data_o,
  output logic                                req_cd_last_o,
  output logic                                snp_ac_valid_o,
  input  logic                                snp_ac_ready_i,
  output logic [AddrWidth-1:0]                snp_ac_addr_o,
  output logic [3:0]                          snp_ac_snoop_o,
  output logic [2:0]                          snp_ac_prot_o,
  output logic [MaskWidth-1:0]                snp_domain_mask_o,
  input  logic                                snp_cr_valid_i,
  output logic                                snp_cr_ready_o,
  input  logic [4:0]                          snp_cr_resp_i,
  input  logic                                snp_cd_valid_i,
  output logic                                snp_cd_ready_o,
  input  logic [DataWidth-1:0]                snp_cd_data_i,
  input  logic                                snp_cd_last_i
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAc   = 2'd1,
    StCr   = 2'd2,
    StCd   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  idx_t                owner_q, owner_d;
  idx_t                rr_ptr_q, rr_ptr_d;
  logic                cd_done_q, cd_done_d;

  logic                pick_valid;
  idx_t                pick_idx;
  idx_t                owner_next;
  logic [NumReq-1:0]   owner_oh;
  logic                cd_route;
  logic                cd_last_hs;
  logic                cr_hs;

  // First valid requester at or after rr_ptr_q, wrapping modulo NumReq.
  always_comb begin : p_pick
    int unsigned cand;
    idx_t        cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      cand_idx = idx_t'(cand);
      if (!pick_valid && req_ac_valid_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign owner_next = (owner_q == idx_t'(NumReq - 1)) ? '0 : owner_q + idx_t'(1);
  assign owner_oh   = NumReq'(1) << owner_q;

  // CD may overtake CR, so the data channel is open in both CR and CD.
  assign cd_route   = (state_q == StCr) || (state_q == StCd);
  assign cd_last_hs = cd_route && snp_cd_valid_i && req_cd_ready_i[owner_q] && snp_cd_last_i;
  assign cr_hs      = (state_q == StCr) && snp_cr_valid_i && req_cr_ready_i[owner_q];

  always_comb begin : p_fsm
    state_d           = state_q;
    owner_d           = owner_q;
    rr_ptr_d          = rr_ptr_q;
    cd_done_d         = cd_done_q;

    req_ac_ready_o    = '0;
    req_cr_valid_o    = '0;
    req_cd_valid_o    = '0;
    req_cr_resp_o     = '0;
    req_cd_data_o     = '0;
    req_cd_last_o     = 1'b0;
    snp_ac_valid_o    = 1'b0;
    snp_ac_addr_o     = '0;
    snp_ac_snoop_o    = '0;
    snp_ac_prot_o     = '0;
    snp_domain_mask_o = '0;
    snp_cr_ready_o    = 1'b0;
    snp_cd_ready_o    = 1'b0;

    if (cd_route) begin
      snp_cd_ready_o = req_cd_ready_i[owner_q];
      req_cd_valid_o = owner_oh & {NumReq{snp_cd_valid_i}};
      req_cd_data_o  = snp_cd_data_i;
      req_cd_last_o  = snp_cd_last_i;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = StAc;
        end
      end

      StAc: begin
        snp_ac_valid_o    = req_ac_valid_i[owner_q];
        snp_ac_addr_o     = req_ac_addr_i[owner_q];
        snp_ac_snoop_o    = req_ac_snoop_i[owner_q];
        snp_ac_prot_o     = req_ac_prot_i[owner_q];
        snp_domain_mask_o = req_domain_mask_i[owner_q];
        req_ac_ready_o    = owner_oh & {NumReq{snp_ac_ready_i}};
        if (req_ac_valid_i[owner_q] && snp_ac_ready_i) begin
          rr_ptr_d  = owner_next;
          cd_done_d = 1'b0;
          state_d   = StCr;
        end
      end

      StCr: begin
        snp_cr_ready_o = req_cr_ready_i[owner_q];
        req_cr_valid_o = owner_oh & {NumReq{snp_cr_valid_i}};
        req_cr_resp_o  = snp_cr_resp_i;
        if (cd_last_hs) begin
          cd_done_d = 1'b1;
        end
        if (cr_hs) begin
          // Bit 0 is DataTransfer; Error/PassDirty never affect sequencing.
          if (!snp_cr_resp_i[0] || cd_done_q || cd_last_hs) begin
            state_d = StIdle;
          end else begin
            state_d = StCd;
          end
        end
      end

      StCd: begin
        if (cd_last_hs) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
    if (!rst_ni) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      cd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cd_done_q <= cd_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccu_snoop_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ccu_snoop_arbiter: directed + randomized checks of the snoop arbiter
// Revision: 1.0 - initial release
// ============================================================================
module tb_ccu_snoop_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 4;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           req_ac_valid;
  logic [N-1:0][AW-1:0]   req_ac_addr;
  logic [N-1:0][3:0]      req_ac_snoop;
  logic [N-1:0][2:0]      req_ac_prot;
  logic [N-1:0][MW-1:0]   req_domain_mask;
  logic [N-1:0]           req_ac_ready_o;
  logic [N-1:0]           req_cr_valid_o;
  logic [N-1:0]           req_cr_ready;
  logic [N-1:0]           req_cd_valid_o;
  logic [N-1:0]           req_cd_ready;
  logic [4:0]             req_cr_resp_o;
  logic [DW-1:0]          req_cd_data_o;
  logic                   req_cd_last_o;
  logic                   snp_ac_valid_o;
  logic                   snp_ac_ready;
  logic [AW-1:0]          snp_ac_addr_o;
  logic [3:0]             snp_ac_snoop_o;
  logic [2:0]             snp_ac_prot_o;
  logic [MW-1:0]          snp_domain_mask_o;
  logic                   snp_cr_valid;
  logic                   snp_cr_ready_o;
  logic [4:0]             snp_cr_resp;
  logic                   snp_cd_valid;
  logic                   snp_cd_ready_o;
  logic [DW-1:0]          snp_cd_data;
  logic                   snp_cd_last;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;  // reference round-robin pointer: next requester in line

  ccu_snoop_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaskWidth(MW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_ac_valid_i(req_ac_valid), .req_ac_addr_i(req_ac_addr),
    .req_ac_snoop_i(req_ac_snoop), .req_ac_prot_i(req_ac_prot),
    .req_domain_mask_i(req_domain_mask), .req_ac_ready_o(req_ac_ready_o),
    .req_cr_valid_o(req_cr_valid_o), .req_cr_ready_i(req_cr_ready),
    .req_cd_valid_o(req_cd_valid_o), .req_cd_ready_i(req_cd_ready),
    .req_cr_resp_o(req_cr_resp_o), .req_cd_data_o(req_cd_data_o),
    .req_cd_last_o(req_cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready),
    .snp_ac_addr_o(snp_ac_addr_o), .snp_ac_snoop_o(snp_ac_snoop_o),
    .snp_ac_prot_o(snp_ac_prot_o), .snp_domain_mask_o(snp_domain_mask_o),
    .snp_cr_valid_i(snp_cr_valid), .snp_cr_ready_o(snp_cr_ready_o),
    .snp_cr_resp_i(snp_cr_resp),
    .snp_cd_valid_i(snp_cd_valid), .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data), .snp_cd_last_i(snp_cd_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester counting up from m_ptr.
  function automatic int m_pick(input logic [N-1:0] pend);
    for (int i = 0; i < N; i++) begin
      if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic set_payload(input int r);
    req_ac_addr[r]     = {$urandom, $urandom};
    req_ac_snoop[r]    = 4'($urandom);
    req_ac_prot[r]     = 3'($urandom);
    req_domain_mask[r] = MW'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ac_valid"}, snp_ac_valid_o, 0);
    chk({tag, "_ac_ready"}, req_ac_ready_o, 0);
    chk({tag, "_cr_valid"}, req_cr_valid_o, 0);
    chk({tag, "_cd_valid"}, req_cd_valid_o, 0);
    chk({tag, "_cr_ready"}, snp_cr_ready_o, 0);
    chk({tag, "_cd_ready"}, snp_cd_ready_o, 0);
    chk({tag, "_cr_resp"},  req_cr_resp_o, 0);
    chk({tag, "_cd_data"},  req_cd_data_o, 0);
    chk({tag, "_cd_last"},  req_cd_last_o, 0);
    chk({tag, "_ac_addr"},  snp_ac_addr_o, 0);
    chk({tag, "_mask"},     snp_domain_mask_o, 0);
  endtask

  // Idle cycle: every downstream channel offered, nothing may pass.
  task automatic idle_probe();
    snp_cr_valid = 1'b1; snp_cd_valid = 1'b1; snp_cr_resp = 5'h1f;
    req_cr_ready = '1;   req_cd_ready = '1;   snp_ac_ready = 1'b1;
    #1;
    chk("idle_ac_valid", snp_ac_valid_o, 0);
    chk("idle_ac_ready", req_ac_ready_o, 0);
    chk("idle_cr_valid", req_cr_valid_o, 0);
    chk("idle_cd_valid", req_cd_valid_o, 0);
    chk("idle_cr_ready", snp_cr_ready_o, 0);
    chk("idle_cd_ready", snp_cd_ready_o, 0);
    snp_cr_valid = 1'b0; snp_cd_valid = 1'b0; snp_cr_resp = '0;
    req_cr_ready = '0;   req_cd_ready = '0;   snp_ac_ready = 1'b0;
  endtask

  task automatic send_beats(input int own, input int beats);
    logic [N-1:0]  oh;
    logic [DW-1:0] d;
    oh = N'(1) << own;
    for (int b = 0; b < beats; b++) begin
      d = {$urandom, $urandom};
      snp_cd_valid = 1'b1; snp_cd_data = d; snp_cd_last = (b == beats - 1);
      if ($urandom_range(0, 2) == 0) begin
        req_cd_ready = ~oh;
        #1;
        chk("cd_stall_ready", snp_cd_ready_o, 0);
        chk("cd_stall_route", req_cd_valid_o, oh);
        @(negedge clk);
      end
      req_cd_ready = oh;
      #1;
      chk("cd_route", req_cd_valid_o, oh);
      chk("cd_ready", snp_cd_ready_o, 1);
      chk("cd_data",  req_cd_data_o, d);
      chk("cd_last",  req_cd_last_o, (b == beats - 1));
      chk("cd_no_ac", {snp_ac_valid_o, req_ac_ready_o}, 0);
      @(negedge clk);
    end
    snp_cd_valid = 1'b0; snp_cd_last = 1'b0; req_cd_ready = '0;
  endtask

  // Full transaction; called at a negedge with the DUT idle and valids set.
  task automatic run_txn(input logic [4:0] resp, input int beats, input bit cd_first,
                         input int ac_stall, input int cr_stall, input bit drop,
                         output int own);
    logic [N-1:0] oh;
    own = m_pick(req_ac_valid);
    if (own < 0) begin
      $display("FAIL run_txn observed=no_request expected=request");
      $fatal(1, "no pending request");
    end
    oh = N'(1) << own;
    idle_probe();
    @(negedge clk);
    for (int k = 0; k <= ac_stall; k++) begin
      snp_ac_ready = (k == ac_stall);
      #1;
      chk("ac_valid", snp_ac_valid_o, 1);
      chk("ac_addr",  snp_ac_addr_o,  req_ac_addr[own]);
      chk("ac_snoop", snp_ac_snoop_o, req_ac_snoop[own]);
      chk("ac_prot",  snp_ac_prot_o,  req_ac_prot[own]);
      chk("ac_mask",  snp_domain_mask_o, req_domain_mask[own]);
      chk("ac_ready", req_ac_ready_o, (k == ac_stall) ? oh : '0);
      @(negedge clk);
    end
    snp_ac_ready = 1'b0;
    m_ptr = (own + 1) % N;
    if (drop) req_ac_valid[own] = 1'b0;
    if (cd_first) send_beats(own, beats);
    snp_cr_resp = resp;
    for (int k = 0; k <= cr_stall; k++) begin
      logic rdy;
      rdy = (k == cr_stall) ? 1'b1 : k[0];
      req_cr_ready = rdy ? oh : ~oh;
      snp_cr_valid = !rdy || (k == cr_stall);
      #1;
      chk("cr_ready_follow", snp_cr_ready_o, rdy);
      chk("cr_route", req_cr_valid_o, snp_cr_valid ? oh : '0);
      chk("cr_resp",  req_cr_resp_o, resp);
      @(negedge clk);
    end
    snp_cr_valid = 1'b0; req_cr_ready = '0; snp_cr_resp = '0;
    if (resp[0] && !cd_first) send_beats(own, beats);
  endtask

  initial begin
    int own;
    logic [4:0] resp;
    bit cdf;

    rst_ni = 1'b0;
    req_ac_valid = '1; snp_ac_ready = 1'b1;
    snp_cr_valid = 1'b1; snp_cr_resp = 5'h1f; req_cr_ready = '1;
    snp_cd_valid = 1'b1; snp_cd_data = '1; snp_cd_last = 1'b1; req_cd_ready = '1;
    for (int r = 0; r < N; r++) set_payload(r);
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    snp_ac_ready = 1'b0; snp_cr_valid = 1'b0; snp_cr_resp = '0; req_cr_ready = '0;
    snp_cd_valid = 1'b0; snp_cd_data = '0; snp_cd_last = 1'b0; req_cd_ready = '0;

    // Contention: both requesters held valid throughout.
    for (int t = 0; t < 4; t++) begin
      run_txn(5'b00000, 0, 1'b0, 0, 0, 1'b0, own);
      chk("cont_order", own, t % 2);
    end
    req_ac_valid = '0;

    // Single request from req0.
    req_ac_addr[0] = 64'h1000; req_ac_snoop[0] = 4'h7;
    req_ac_valid = 2'b01;
    run_txn(5'b00000, 0, 1'b0, 0, 0, 1'b1, own);
    chk("single_owner", own, 0);

    // Data transfer: pointer now favours req1; req0 waits through 4 beats.
    req_ac_valid = 2'b11;
    run_txn(5'b00101, 4, 1'b0, 0, 1, 1'b1, own);
    chk("dt_owner", own, 1);

    // CD before CR: req0 still pending.
    run_txn(5'b00001, 2, 1'b1, 0, 0, 1'b1, own);
    chk("cdfirst_owner", own, 0);

    // Backpressure on AC and a toggling owner CR ready.
    req_ac_valid = 2'b11;
    run_txn(5'b00000, 0, 1'b0, 5, 4, 1'b1, own);
    chk("bp_owner", own, 1);
    req_ac_valid = '0;

    // Reset in the middle of a CD burst.
    req_ac_valid = 2'b01;
    idle_probe();
    @(negedge clk);
    snp_ac_ready = 1'b1;
    #1;
    chk("midcd_ac_ready", req_ac_ready_o, 2'b01);
    @(negedge clk);
    snp_ac_ready = 1'b0; req_ac_valid = '0;
    snp_cr_valid = 1'b1; snp_cr_resp = 5'b00001; req_cr_ready = 2'b01;
    #1;
    chk("midcd_cr_route", req_cr_valid_o, 2'b01);
    @(negedge clk);
    snp_cr_valid = 1'b0; snp_cr_resp = '0; req_cr_ready = '0;
    for (int b = 0; b < 2; b++) begin
      snp_cd_valid = 1'b1; snp_cd_data = {$urandom, $urandom}; snp_cd_last = 1'b0;
      req_cd_ready = 2'b01;
      #1;
      chk("midcd_beat", req_cd_valid_o, 2'b01);
      @(negedge clk);
    end
    rst_ni = 1'b0;
    #1;
    chk_all_zero("midcd_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    snp_cd_valid = 1'b0; req_cd_ready = '0;
    m_ptr = 0;
    req_ac_valid = 2'b11;
    run_txn(5'b00000, 0, 1'b0, 0, 0, 1'b1, own);
    chk("post_rst_owner", own, 0);
    run_txn(5'b00000, 0, 1'b0, 0, 0, 1'b1, own);
    chk("post_rst_req1", own, 1);

    // Randomized traffic against the reference pointer.
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < N; r++) begin
        if (!req_ac_valid[r] && ($urandom_range(0, 1) == 1)) begin
          set_payload(r);
          req_ac_valid[r] = 1'b1;
        end
      end
      if (req_ac_valid == '0) begin
        own = $urandom_range(0, N - 1);
        set_payload(own);
        req_ac_valid[own] = 1'b1;
      end
      resp = 5'($urandom);
      cdf  = resp[0] && ($urandom_range(0, 1) == 1);
      run_txn(resp, $urandom_range(1, 4), cdf, $urandom_range(0, 3),
              $urandom_range(0, 2), 1'b1, own);
    end
    req_ac_valid = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccu_snoop_arbiter.md
# ccu_snoop_arbiter

Shares the single snoop-crossbar port of the CCU between several snoop-issuing controllers, such as the read-snoop and write-snoop FSMs. Requests are granted round-robin. One snoop transaction is in flight at a time: the AC request, its CR response and any CD data burst. CR and CD are routed back to the granted requester only. The block sits between the CCU snoop controllers and the snoop crossbar, and also muxes the per-requester domain mask that travels with AC.

## Interface
- NumReq, 2, number of snoop-issuing controllers (≥2).
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- MaskWidth, 4, domain mask width (one bit per cached master).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_ac_valid_i  in  NumReq  per-requester AC valid.
- req_ac_addr_i  in  NumReq×AddrWidth  AC address.
- req_ac_snoop_i  in  NumReq×4  AC snoop type.
- req_ac_prot_i  in  NumReq×3  AC prot.
- req_domain_mask_i  in  NumReq×MaskWidth  domain mask travelling with AC.
- req_ac_ready_o  out  NumReq  AC ready per requester.
- req_cr_valid_o  out  NumReq  CR valid per requester.
- req_cr_ready_i  in  NumReq  CR ready per requester.
- req_cd_valid_o  out  NumReq  CD valid per requester.
- req_cd_ready_i  in  NumReq  CD ready per requester.
- req_cr_resp_o  out  5  CR response, broadcast.
- req_cd_data_o  out  DataWidth  CD data, broadcast.
- req_cd_last_o  out  1  CD last, broadcast.
- snp_ac_valid_o / snp_ac_ready_i  out/in  1  downstream AC handshake.
- snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o  out  AddrWidth/4/3  downstream AC payload.
- snp_domain_mask_o  out  MaskWidth  mask of the granted requester.
- snp_cr_valid_i / snp_cr_ready_o  in/out  1  downstream CR handshake.
- snp_cr_resp_i  in  5  CR bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- snp_cd_valid_i / snp_cd_ready_o  in/out  1  downstream CD handshake.
- snp_cd_data_i, snp_cd_last_i  in  DataWidth/1  CD payload.

## Operation
- FSM states: IDLE, AC, CR, CD.
- Registered state: the FSM state, owner_q (index), rr_ptr_q, cd_done_q.
- IDLE:
  - Pick the first requester with ac_valid at or after rr_ptr_q, wrapping modulo NumReq.
  - Register that index in owner_q and go to AC.
  - No outputs are asserted.
- AC:
  - snp_ac_valid_o = req_ac_valid_i[owner_q]. Payload and mask are muxed from owner_q.
  - req_ac_ready_o[owner_q] = snp_ac_ready_i. All other ac_ready bits are 0.
  - On handshake: rr_ptr_q ← owner_q+1 (wrapping), cd_done_q ← 0, go to CR.
  - A requester that drops ac_valid before the handshake violates protocol. The behaviour is not required; the block stays in AC.
- CR:
  - CR is passed through to the owner: snp_cr_ready_o = req_cr_ready_i[owner_q], req_cr_valid_o[owner_q] = snp_cr_valid_i.
  - CD is also passed through to the owner in this state, because CD may precede CR.
  - A CD handshake with last sets cd_done_q.
  - On CR handshake with DataTransfer=0: go to IDLE.
  - On CR handshake with DataTransfer=1 and cd_done_q (or CD last in the same cycle): go to IDLE.
  - Otherwise, on CR handshake: go to CD.
- CD:
  - CD is passed through to the owner.
  - A CD handshake with last returns the FSM to IDLE.
- Routing: a non-owner never sees valid on CR or CD. CR/CD/AC ready toward downstream is 0 in IDLE.
- The Error and PassDirty bits are forwarded unchanged and do not change sequencing.

## Timing
- Reset: all outputs 0. State = IDLE, owner_q = 0, rr_ptr_q = 0, cd_done_q = 0.
- Arbitration latency: one cycle. A request in IDLE at cycle t gives snp_ac_valid_o at t+1.
- After the last handshake (CR, or CD last) in cycle t, the FSM is in IDLE at t+1 and asserts AC no earlier than t+2.
- Back-to-back requesters therefore see a minimum of 2 idle AC cycles between transactions.
- AC payload is stable while snp_ac_valid_o=1 and not accepted: owner_q is frozen in AC.
- Simultaneous requests: grant follows the round-robin order. A requester waits at most NumReq−1 transactions.
- Simultaneous CR handshake and CD last in CR state: treated as complete; the FSM goes directly to IDLE.
- Reset mid-transaction: returns immediately to IDLE with all handshake outputs 0. The downstream side is reset together with this block.

## Test plan
- Single request:
  - req0 AC addr=0x1000, snoop=0x7.
  - Required: AC at t+1. CR 5'b00000 forwarded to req0 only. IDLE next cycle. rr_ptr_q=1.
- Contention:
  - req0 and req1 both valid from reset.
  - Required: grant order 0,1,0,1 over 4 transactions. req1 ac_ready is held 0 during req0's transaction.
- Data transfer:
  - CR resp=5'b00101 (DataTransfer, PassDirty), then a 4-beat CD with last on beat 4.
  - Required: all 4 beats reach the owner. The next grant occurs only after the last beat.
- CD before CR:
  - 2 CD beats with last complete in CR state, then CR resp=5'b00001.
  - Required: the FSM goes directly to IDLE and does not enter CD.
- Backpressure:
  - snp_ac_ready_i held 0 for 5 cycles while req1 is also valid.
  - Required: AC payload stable and owner unchanged.
  - Required: a toggling req_cr_ready_i of the owner stalls snp_cr_ready_o identically.
- Reset mid-CD:
  - Assert rst_ni=0 after CD beat 2.
  - Required: all outputs 0 and state IDLE. A new req1 request after reset is granted (rr_ptr=0, first valid at or after 0).
